pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush scheduler for the 5-stage pipeline register bank.
//  Sits beside the F/D/E/M/W registers and produces their hold and bubble controls.
//  Sources: bus handshakes, load-use hazards and branch redirects.
//  Sequences redirects that arrive while an ifetch is outstanding.
//  Flags bus hangs via a watchdog.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  bus-wait cycles before error is raised (>=2)
//  PC_W            64    PC / redirect target width
//  REG_W           5     architectural register index width
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      asynchronous, active-low reset
//  ireq_valid     in   1      ifetch request outstanding on ibus
//  iresp_data_ok  in   1      ifetch response this cycle
//  dreq_valid     in   1      data request outstanding on dbus
//  dresp_data_ok  in   1      data response this cycle
//  br_taken       in   1      execute stage resolves a taken branch/jump
//  br_target      in   PC_W   branch target PC
//  id_rs1,id_rs2  in   REG_W  decode-stage source registers
//  id_use_rs1/2   in   1      decode instruction reads rs1/rs2
//  ex_rd          in   REG_W  execute-stage destination
//  ex_is_load     in   1      execute-stage instruction is a load
//  stallpc        out  1      hold PC
//  stallf         out  1      hold F register
//  stalld         out  1      inject bubble into D register
//  stallm         out  1      freeze F/D/E/M registers (dbus wait)
//  flushF         out  1      zero F/D/E registers (squash wrong path)
//  redirect_valid out  1      load redirect_pc into PC this cycle
//  redirect_pc    out  PC_W   redirect target
//  error          out  1      sticky bus-timeout flag
// BEHAVIOUR
//  - Reset (reset==0, async): state=RUN, counters 0, pending target 0; all outputs 0.
//  - stallm = dreq_valid & ~dresp_data_ok. Combinational, zero latency; highest priority.
//  - Load-use: lu = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//    Asserts stallpc, stallf, stalld for exactly one cycle; state LU_BUB.
//    LU_BUB masks lu for one cycle, then returns to RUN.
//  - FSM states: RUN, LU_BUB, DRAIN, REDIR.
//    RUN, br_taken & ~stallm, no fetch outstanding (~ireq_valid | iresp_data_ok):
//      redirect_valid=1, redirect_pc=br_target, flushF=1 same cycle; stay RUN.
//    RUN, br_taken & ~stallm, fetch outstanding (ireq_valid & ~iresp_data_ok):
//      latch br_target; flushF=1; stallpc=1; ->DRAIN.
//    DRAIN: stallpc=1 and flushF=1 each cycle (wrong-path fetch discarded).
//      On iresp_data_ok -> REDIR.
//    REDIR: redirect_valid=1 with latched target, flushF=1; -> RUN next cycle.
//  - br_taken is ignored while stallm=1. E is frozen, so the branch re-presents.
//  - Priority on simultaneous events: reset > stallm > branch > load-use.
//    A branch drops a concurrent load-use bubble.
//  - br_taken in DRAIN/REDIR is ignored (younger, already-squashed path).
//  - Watchdog:
//    - 16-bit counter increments while stallm=1 or state==DRAIN; clears otherwise.
//    - At count==TIMEOUT_CYCLES-1, error<=1, sticky until reset.
//    - Counter saturates at that value; pipeline behaviour is unchanged.
//  - Reset mid-DRAIN: pending redirect discarded; no redirect after release.
// CONFIGURATION
//  PIPELINE_HAZARD_PERF_EN defined:
//   - Adds outputs perf_stall_cyc[63:0], perf_lu_cnt[31:0], perf_flush_cnt[31:0].
//   - perf_stall_cyc counts cycles with stallm|stallpc.
//   - perf_lu_cnt counts load-use bubbles.
//   - perf_flush_cnt counts accepted branches.
//   - All counters reset to 0 and wrap on overflow.
//  PIPELINE_HAZARD_PERF_EN undefined: ports and counters absent; other behaviour identical.
// STRUCTURE
//  - hz_state_t enum {RUN,LU_BUB,DRAIN,REDIR} and HZ_TIMEOUT_W=16 live in package pipes.
//  - Sub-module hazard_detect: combinational load-use compare (rs/rd, x0 exclusion).
//  - FSM, watchdog and perf counters stay in this module.
// TESTING
//  1. reset low 3 cycles, mid-cycle release -> all outputs 0; state RUN.
//  2. lw x5 in E, add x6,x5,x7 in D
//     -> stallpc/stallf/stalld high exactly 1 cycle, then 0.
//  3. dreq_valid=1, dresp_data_ok after 4 cycles
//     -> stallm high 4 cycles; br_taken during that window has no effect.
//  4. br_taken, target 0x8000_0100, ireq_valid=1, iresp_data_ok after 3 cycles
//     -> flushF for 4 cycles, then redirect_valid with 0x8000_0100.
//  5. br_taken with no fetch outstanding, simultaneous lu
//     -> same-cycle redirect; stalld=0; no LU_BUB.
//  6. TIMEOUT_CYCLES=8, dreq held 10 cycles
//     -> error rises on 8th stalled cycle and stays 1 after release.
//     With PERF_EN: perf_stall_cyc==10.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipes;

   // Scheduler modes: normal issue, post-load-use bubble, waiting out a
   // wrong-path fetch, and the cycle that applies a deferred redirect.
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      LU_BUB = 2'd1,
      DRAIN  = 2'd2,
      REDIR  = 2'd3
   } hz_state_t;

   // Width of the bus-hang watchdog counter.
   localparam int HZ_TIMEOUT_W = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// rtl/pipeline_hazard_ctrl_hazard_detect.sv - combinational load-use hazard compare
module hazard_detect #(
   parameter int REG_W = 5
) (
   input  logic             ex_is_load_i,
   input  logic [REG_W-1:0] ex_rd_i,
   input  logic [REG_W-1:0] id_rs1_i,
   input  logic [REG_W-1:0] id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   output logic             lu_o
);

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign lu_o = ex_is_load_i && (ex_rd_i != '0) &&
                 ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                  (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush scheduler for the 5-stage pipeline; optional PIPELINE_HAZARD_PERF_EN counters
module pipeline_hazard_ctrl
   import pipes::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int PC_W           = 64,
   parameter int REG_W          = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ireq_valid,
   input  logic             iresp_data_ok,
   input  logic             dreq_valid,
   input  logic             dresp_data_ok,
   input  logic             br_taken,
   input  logic [PC_W-1:0]  br_target,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_is_load,
   output logic             stallpc,
   output logic             stallf,
   output logic             stalld,
   output logic             stallm,
   output logic             flushF,
   output logic             redirect_valid,
   output logic [PC_W-1:0]  redirect_pc,
`ifdef PIPELINE_HAZARD_PERF_EN
   output logic [63:0]      perf_stall_cyc,
   output logic [31:0]      perf_lu_cnt,
   output logic [31:0]      perf_flush_cnt,
`endif
   output logic             error
);

   localparam logic [HZ_TIMEOUT_W-1:0] WD_MAX = HZ_TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   hz_state_t              state_q, state_d;
   logic [PC_W-1:0]        tgt_q, tgt_d;
   logic [HZ_TIMEOUT_W-1:0] wd_q, wd_d;
   logic                   err_q, err_d;
   logic                   lu;
   logic                   br_acc;
   logic                   wd_active;

   hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
      .ex_is_load_i (ex_is_load),
      .ex_rd_i      (ex_rd),
      .id_rs1_i     (id_rs1),
      .id_rs2_i     (id_rs2),
      .id_use_rs1_i (id_use_rs1),
      .id_use_rs2_i (id_use_rs2),
      .lu_o         (lu)
   );

   // Next-state and pipeline controls; a dbus wait outranks branches, which outrank load-use.
   always_comb begin
      state_d        = state_q;
      tgt_d          = tgt_q;
      stallm         = reset & dreq_valid & ~dresp_data_ok;
      stallpc        = 1'b0;
      stallf         = 1'b0;
      stalld         = 1'b0;
      flushF         = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      br_acc         = 1'b0;
      if (reset) begin
         case (state_q)
            RUN, LU_BUB: begin
               state_d = RUN;
               if (br_taken && !stallm) begin
                  br_acc = 1'b1;
                  flushF = 1'b1;
                  if (ireq_valid && !iresp_data_ok) begin
                     // The in-flight fetch belongs to the wrong path: park the target until it lands.
                     tgt_d   = br_target;
                     stallpc = 1'b1;
                     state_d = DRAIN;
                  end else begin
                     redirect_valid = 1'b1;
                     redirect_pc    = br_target;
                  end
               end else if (lu && !stallm && (state_q == RUN)) begin
                  stallpc = 1'b1;
                  stallf  = 1'b1;
                  stalld  = 1'b1;
                  state_d = LU_BUB;
               end
            end
            DRAIN: begin
               stallpc = 1'b1;
               flushF  = 1'b1;
               if (iresp_data_ok) state_d = REDIR;
            end
            REDIR: begin
               redirect_valid = 1'b1;
               redirect_pc    = tgt_q;
               flushF         = 1'b1;
               state_d        = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   // Watchdog: counts consecutive bus-wait cycles; error latches on the cycle the count sits at its limit.
   always_comb begin
      wd_active = stallm | (state_q == DRAIN);
      wd_d      = '0;
      err_d     = err_q;
      if (wd_active) begin
         wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + HZ_TIMEOUT_W'(1);
         if (wd_q == WD_MAX) err_d = 1'b1;
      end
   end

   // State, pending target and watchdog registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         tgt_q   <= '0;
         wd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
      end
   end

   assign error = err_q;

`ifdef PIPELINE_HAZARD_PERF_EN
   // Free-running event counters; they wrap naturally on overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall_cyc <= '0;
         perf_lu_cnt    <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (stallm || stallpc) perf_stall_cyc <= perf_stall_cyc + 64'd1;
         if (stalld)            perf_lu_cnt    <= perf_lu_cnt + 32'd1;
         if (br_acc)            perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule
